// File: rtl/cry_pkg.sv
// rtl/cry_pkg.sv - shared field layout, stage types and bit-expansion helper for CRY/RGB16 conversion
package cry_pkg;

  // CRY pixel: [15:12] cyan, [11:8] red, [7:0] intensity.
  localparam int CRY_C_MSB     = 15;
  localparam int CRY_R_MSB     = 11;
  localparam int CRY_Y_MSB     = 7;
  localparam int CRY_COLOR_LSB = CRY_R_MSB - 3;
  localparam int CRY_COLOR_W   = CRY_C_MSB - CRY_COLOR_LSB + 1;
  localparam int CRY_Y_W       = CRY_Y_MSB + 1;

  // RGB16 pixel: [15:11] red, [10:6] blue, [5:0] green.
  localparam int RGB16_R_MSB = 15;
  localparam int RGB16_R_W   = 5;
  localparam int RGB16_B_MSB = 10;
  localparam int RGB16_B_W   = 5;
  localparam int RGB16_G_MSB = 5;
  localparam int RGB16_G_W   = 6;

  // First pipeline stage: pixel captured at accept.
  typedef struct packed {
    logic        v;
    logic [7:0]  y;
    logic [7:0]  color;
    logic        cry;
    logic [15:0] rgb;
  } s1_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  // Widen an n-bit channel (4 <= n <= 8) to 8 bits by repeating its top bits
  // into the vacated LSBs, so full-scale maps to 0xFF and zero stays zero.
  function automatic logic [7:0] expand_to8(input logic [7:0] field, input int width);
    logic [7:0] mask;
    logic [7:0] f;
    mask = 8'hFF >> (8 - width);
    f    = field & mask;
    return (f << (8 - width)) | (f >> (2 * width - 8));
  endfunction

endpackage

// File: rtl/cry_scale8.sv
// rtl/cry_scale8.sv - scale one 8-bit base component by an 8-bit intensity
module cry_scale8 (
  input  logic [7:0] base,
  input  logic [7:0] y,
  output logic [7:0] comp
);

  logic [15:0] prod;
  logic [15:0] sum;

  // base*(y+1)/256: Y=0 gives 0, Y=0xFF returns base exactly; the sum
  // never exceeds 0xFF00, so 16 bits hold it without carry-out.
  always_comb begin
    prod = {8'd0, base} * {8'd0, y};
    sum  = prod + {8'd0, base};
    comp = sum[15:8];
  end

endmodule

// File: rtl/cry_rgb_scale.sv
// rtl/cry_rgb_scale.sv - CRY/RGB16 to RGB24 conversion stage behind the CRY colour ROMs
module cry_rgb_scale
  import cry_pkg::*;
#(
  parameter int unsigned PIPE_OUT = 1
) (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_pix,
  input  logic        in_cry,
  output logic [7:0]  cry_addr,
  input  logic [7:0]  rom_r,
  input  logic [7:0]  rom_g,
  input  logic [7:0]  rom_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b
);

  s1_t        s1_q;
  s1_t        s1_d;
  logic       acc;
  logic       adv1;
  logic       v2;
  logic [7:0] scale_r;
  logic [7:0] scale_g;
  logic [7:0] scale_b;
  rgb24_t     comp;

  // Handshake and ROM address: while S1 is stalled the ROMs keep re-reading
  // color1, so the registered ROM data always matches the pixel held in S1.
  always_comb begin
    if (PIPE_OUT != 0) begin
      adv1 = s1_q.v & (~v2 | out_ready);
    end else begin
      adv1 = s1_q.v & out_ready;
    end
    in_ready = resetl & (~s1_q.v | adv1);
    acc      = in_valid & in_ready;
    cry_addr = acc ? in_pix[CRY_C_MSB -: CRY_COLOR_W] : s1_q.color;
  end

  // S1 next state: load on accept, otherwise drain when the pixel moves on.
  always_comb begin
    s1_d = s1_q;
    if (acc) begin
      s1_d.v     = 1'b1;
      s1_d.y     = in_pix[CRY_Y_MSB -: CRY_Y_W];
      s1_d.color = in_pix[CRY_C_MSB -: CRY_COLOR_W];
      s1_d.cry   = in_cry;
      s1_d.rgb   = in_pix;
    end else if (adv1) begin
      s1_d.v = 1'b0;
    end
  end

  // S1 register; reset discards any in-flight pixel.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  cry_scale8 u_scale_r (.base(rom_r), .y(s1_q.y), .comp(scale_r));
  cry_scale8 u_scale_g (.base(rom_g), .y(s1_q.y), .comp(scale_g));
  cry_scale8 u_scale_b (.base(rom_b), .y(s1_q.y), .comp(scale_b));

  // Per-pixel mode select: scaled ROM colour for CRY, bit-replicated channels for RGB16.
  always_comb begin
    if (s1_q.cry) begin
      comp.r = scale_r;
      comp.g = scale_g;
      comp.b = scale_b;
    end else begin
      comp.r = expand_to8({3'd0, s1_q.rgb[RGB16_R_MSB -: RGB16_R_W]}, RGB16_R_W);
      comp.g = expand_to8({2'd0, s1_q.rgb[RGB16_G_MSB -: RGB16_G_W]}, RGB16_G_W);
      comp.b = expand_to8({3'd0, s1_q.rgb[RGB16_B_MSB -: RGB16_B_W]}, RGB16_B_W);
    end
  end

  generate
    if (PIPE_OUT != 0) begin : g_pipe
      logic   v2_q;
      logic   v2_d;
      rgb24_t out_q;
      rgb24_t out_d;

      // S2 next state: capture when S1 advances, empty when consumed with nothing behind.
      always_comb begin
        v2_d  = v2_q;
        out_d = out_q;
        if (adv1) begin
          v2_d  = 1'b1;
          out_d = comp;
        end else if (out_ready) begin
          v2_d = 1'b0;
        end
      end

      // S2 register; outputs hold while out_valid is not accepted.
      always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
          v2_q  <= 1'b0;
          out_q <= '0;
        end else begin
          v2_q  <= v2_d;
          out_q <= out_d;
        end
      end

      assign v2        = v2_q;
      assign out_valid = v2_q;
      assign out_r     = out_q.r;
      assign out_g     = out_q.g;
      assign out_b     = out_q.b;
    end else begin : g_comb
      assign v2        = 1'b0;
      assign out_valid = s1_q.v;
      assign out_r     = comp.r;
      assign out_g     = comp.g;
      assign out_b     = comp.b;
    end
  endgenerate

endmodule

// File: tb/tb_cry_rgb_scale.sv
// tb/tb_cry_rgb_scale.sv - randomized self-checking bench for cry_rgb_scale
module tb_cry_rgb_scale;

  logic        sys_clk;
  logic        resetl;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pix;
  logic        in_cry;
  logic [7:0]  cry_addr;
  logic [7:0]  rom_r = 8'd0;
  logic [7:0]  rom_g = 8'd0;
  logic [7:0]  rom_b = 8'd0;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_r;
  logic [7:0]  out_g;
  logic [7:0]  out_b;

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [7:0]  tbl_r [256];
  logic [7:0]  tbl_g [256];
  logic [7:0]  tbl_b [256];
  logic [23:0] exp_q [$];
  logic [23:0] sb_exp;

  cry_rgb_scale #(.PIPE_OUT(1)) dut (
    .sys_clk   (sys_clk),
    .resetl    (resetl),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .in_cry    (in_cry),
    .cry_addr  (cry_addr),
    .rom_r     (rom_r),
    .rom_g     (rom_g),
    .rom_b     (rom_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Registered colour ROMs, one cycle of latency.
  always @(posedge sys_clk) begin
    rom_r <= tbl_r[cry_addr];
    rom_g <= tbl_g[cry_addr];
    rom_b <= tbl_b[cry_addr];
  end

  // Reference conversion from pixel rules: CRY scales table colour by (Y+1)/256,
  // RGB16 widens each channel by repeating its top bits.
  function automatic logic [23:0] model(input logic [15:0] pix, input logic cry);
    int unsigned y, rc, gc, bc, r5, b5, g6;
    logic [7:0] col;
    col = pix[15:8];
    if (cry) begin
      y  = 32'(pix[7:0]);
      rc = (32'(tbl_r[col]) * (y + 1)) / 256;
      gc = (32'(tbl_g[col]) * (y + 1)) / 256;
      bc = (32'(tbl_b[col]) * (y + 1)) / 256;
    end else begin
      r5 = 32'(pix[15:11]);
      b5 = 32'(pix[10:6]);
      g6 = 32'(pix[5:0]);
      rc = r5 * 8 + r5 / 4;
      bc = b5 * 8 + b5 / 4;
      gc = g6 * 4 + g6 / 16;
    end
    return {8'(rc), 8'(gc), 8'(bc)};
  endfunction

  // Scoreboard: every accepted pixel must come out once, in order, with the model value.
  always @(negedge sys_clk) begin
    if (!resetl) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: got %h with no pixel outstanding", {out_r, out_g, out_b});
        end else begin
          sb_exp = exp_q.pop_front();
          if ({out_r, out_g, out_b} !== sb_exp)
            $display("FAIL sb_data: got %h expected %h", {out_r, out_g, out_b}, sb_exp);
          else
            pass_cnt++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_pix, in_cry));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Tasks start and end at 1 time unit after a rising edge.
  task automatic send(input logic [15:0] pix, input logic cry);
    int n;
    in_pix   = pix;
    in_cry   = cry;
    in_valid = 1'b1;
    n = 0;
    @(negedge sys_clk);
    while (!in_ready && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    if (!in_ready) begin
      check_cnt++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Returns the number of falling edges seen without out_valid before it appeared.
  task automatic wait_out(output int lat, output logic [23:0] rgb, output bit ok);
    lat = 0;
    ok  = 1'b0;
    rgb = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (out_valid) begin
        ok  = 1'b1;
        rgb = {out_r, out_g, out_b};
        break;
      end
      lat++;
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL drain: got %0d outstanding pixels expected 0", exp_q.size());
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    resetl    = 1'b0;
    in_valid  = 1'b1;
    in_pix    = 16'hABCD;
    in_cry    = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    check_cnt++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    else pass_cnt++;
    check_cnt++;
    if (cry_addr !== 8'h00) $display("FAIL reset_cry_addr: got %h expected 00", cry_addr);
    else pass_cnt++;
    check_cnt++;
    if ({out_r, out_g, out_b} !== 24'h0) $display("FAIL reset_rgb: got %h expected 000000", {out_r, out_g, out_b});
    else pass_cnt++;
    @(posedge sys_clk);
    #1;
    resetl   = 1'b1;
    in_valid = 1'b0;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_cry_basic();
    int          lat;
    logic [23:0] rgb;
    bit          ok;
    out_ready = 1'b1;
    in_pix    = 16'h00FF;
    in_cry    = 1'b1;
    in_valid  = 1'b1;
    @(negedge sys_clk);
    check_cnt++;
    if (in_ready !== 1'b1 || cry_addr !== 8'h00)
      $display("FAIL cry_accept_addr: got in_ready=%b addr=%h expected 1/00", in_ready, cry_addr);
    else pass_cnt++;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    wait_out(lat, rgb, ok);
    // Accept edge then one more edge: out_valid is first seen one falling edge late.
    check_cnt++;
    if (!ok || lat != 1) $display("FAIL cry_latency: got ok=%0d lat=%0d expected ok=1 lat=1", ok, lat);
    else pass_cnt++;
    check_cnt++;
    if (rgb[7:0] !== 8'hFF) $display("FAIL cry_y_ff_blue: got %h expected ff", rgb[7:0]);
    else pass_cnt++;
    check_cnt++;
    if (rgb[23:8] !== {tbl_r[0], tbl_g[0]})
      $display("FAIL cry_y_ff_rg: got %h expected %h", rgb[23:8], {tbl_r[0], tbl_g[0]});
    else pass_cnt++;

    send(16'h1F80, 1'b1);
    wait_out(lat, rgb, ok);
    check_cnt++;
    if (rgb[7:0] !== 8'h6F) $display("FAIL cry_half_blue: got %h expected 6f", rgb[7:0]);
    else pass_cnt++;

    send(16'h8F80, 1'b1);
    wait_out(lat, rgb, ok);
    check_cnt++;
    if (rgb[7:0] !== 8'h00) $display("FAIL cry_zero_base_blue: got %h expected 00", rgb[7:0]);
    else pass_cnt++;
  endtask

  task automatic test_rgb16();
    int          lat;
    logic [23:0] rgb;
    bit          ok;
    out_ready = 1'b1;
    send(16'hFFFF, 1'b0);
    wait_out(lat, rgb, ok);
    check_cnt++;
    if (rgb !== 24'hFFFFFF) $display("FAIL rgb16_full: got %h expected ffffff", rgb);
    else pass_cnt++;
    send(16'h8420, 1'b0);
    wait_out(lat, rgb, ok);
    // {r,g,b} = 84, 82, 84
    check_cnt++;
    if (rgb !== 24'h848284) $display("FAIL rgb16_mid: got %h expected 848284", rgb);
    else pass_cnt++;
  endtask

  task automatic test_zero_y();
    int          lat;
    logic [23:0] rgb;
    bit          ok;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send({8'($urandom), 8'h00}, 1'b1);
      wait_out(lat, rgb, ok);
      check_cnt++;
      if (!ok || rgb !== 24'h0) $display("FAIL zero_y: got ok=%0d rgb=%h expected 000000", ok, rgb);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pix [4];
    logic [23:0] held;
    bit          seen;
    for (int i = 0; i < 4; i++) pix[i] = 16'($urandom);
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) send(pix[i], 1'b1);
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(posedge sys_clk);
          #1;
          if (out_valid) seen = 1'b1;
        end
        check_cnt++;
        if (!seen) $display("FAIL bp_first_valid: got none expected out_valid");
        else pass_cnt++;
        held = {out_r, out_g, out_b};
        check_cnt++;
        if (held !== model(pix[0], 1'b1)) $display("FAIL bp_first_data: got %h expected %h", held, model(pix[0], 1'b1));
        else pass_cnt++;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge sys_clk);
          check_cnt++;
          if (!out_valid || {out_r, out_g, out_b} !== held)
            $display("FAIL bp_hold: got v=%b %h expected v=1 %h", out_valid, {out_r, out_g, out_b}, held);
          else pass_cnt++;
          check_cnt++;
          if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", in_ready);
          else pass_cnt++;
          check_cnt++;
          if (cry_addr !== pix[1][15:8]) $display("FAIL bp_cry_addr: got %h expected %h", cry_addr, pix[1][15:8]);
          else pass_cnt++;
        end
        @(posedge sys_clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_mixed();
    int  run;
    bit  seen;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) send(16'($urandom), 1'(i % 2));
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge sys_clk);
          if (out_valid) seen = 1'b1;
        end
        run = seen ? 1 : 0;
        for (int i = 0; i < 15; i++) begin
          @(negedge sys_clk);
          if (out_valid) run++;
        end
        check_cnt++;
        if (run != 16) $display("FAIL mixed_no_bubble: got %0d valid cycles expected 16", run);
        else pass_cnt++;
      end
    join
    @(posedge sys_clk);
    #1;
    wait_drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_pix    = 16'($urandom);
      in_cry    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge sys_clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_midstream();
    int          lat;
    logic [23:0] rgb;
    bit          ok;
    logic [15:0] pc;
    out_ready = 1'b0;
    send(16'($urandom), 1'b1);
    send(16'($urandom), 1'b0);
    check_cnt++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL rst_full: got v=%b rdy=%b expected 1/0", out_valid, in_ready);
    else pass_cnt++;
    in_pix   = 16'hFFFF;
    in_valid = 1'b1;
    #2;
    resetl = 1'b0;
    #1;
    check_cnt++;
    if (out_valid !== 1'b0 || {out_r, out_g, out_b} !== 24'h0)
      $display("FAIL rst_async_out: got v=%b %h expected 0 000000", out_valid, {out_r, out_g, out_b});
    else pass_cnt++;
    check_cnt++;
    if (in_ready !== 1'b0 || cry_addr !== 8'h00)
      $display("FAIL rst_async_in: got rdy=%b addr=%h expected 0/00", in_ready, cry_addr);
    else pass_cnt++;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    resetl    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge sys_clk);
      check_cnt++;
      if (out_valid !== 1'b0) $display("FAIL rst_stale: got out_valid=%b expected 0", out_valid);
      else pass_cnt++;
    end
    @(posedge sys_clk);
    #1;
    pc = 16'($urandom);
    send(pc, 1'b1);
    wait_out(lat, rgb, ok);
    check_cnt++;
    if (!ok || lat != 1 || rgb !== model(pc, 1'b1))
      $display("FAIL rst_first_pixel: got ok=%0d lat=%0d %h expected 1 1 %h", ok, lat, rgb, model(pc, 1'b1));
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbl_r[i] = 8'($urandom);
      tbl_g[i] = 8'($urandom);
      tbl_b[i] = 8'($urandom);
    end
    tbl_b[8'h00] = 8'hFF;
    tbl_b[8'h1F] = 8'hDD;
    tbl_b[8'h8F] = 8'h00;
    in_valid  = 1'b0;
    in_pix    = 16'h0;
    in_cry    = 1'b0;
    out_ready = 1'b1;
    resetl    = 1'b0;

    test_reset();
    test_cry_basic();
    test_rgb16();
    test_zero_y();
    test_backpressure();
    test_mixed();
    test_random();
    test_reset_midstream();
    wait_drain();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/cry_rgb_scale.md
Name: cry_rgb_scale

Overview:
- Pixel-conversion stage sitting directly downstream of the CRY colour lookup ROMs (red, green, blue; 256x8 each, registered output, 1-cycle latency).
- Accepts 16-bit pixels: CRY (colour byte + intensity byte) or RGB16.
- Drives the shared ROM address, scales each ROM base component by intensity, and emits 24-bit RGB.
- Uses a valid/ready handshake on both sides, so the video pipeline can stall it.

Parameters:
- PIPE_OUT, 1: 1 = register the final RGB (2 pipeline stages after accept); 0 = combinational output from the multiply stage.

Ports:
- sys_clk  in  1  Single clock for the block and the ROMs.
- resetl  in  1  Asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  Input pixel valid.
- in_ready  out  1  Block can accept a pixel this cycle.
- in_pix  in  16  Pixel data. CRY: [15:12] cyan, [11:8] red, [7:0] Y. RGB16: [15:11] R, [10:6] B, [5:0] G.
- in_cry  in  1  1 = CRY pixel, 0 = RGB16; sampled with the pixel.
- cry_addr  out  8  Address to the red/green/blue ROMs.
- rom_r, rom_g, rom_b  in  8 each  ROM data; valid 1 cycle after the address.
- out_valid  out  1  RGB output valid.
- out_ready  in  1  Downstream accepts.
- out_r, out_g, out_b  out  8 each  Scaled RGB.

Behaviour:
- Accept: acc = in_valid & in_ready.
- Stage S1 register holds: v1, y1 (8), color1 (8), cry1, rgb1 (16, raw pixel).
  - On acc, S1 loads from in_pix / in_cry.
- Stage S2 register (when PIPE_OUT=1): v2, out_r/g/b.
- in_ready = ~v1 | adv1, where adv1 = v1 & (~v2 | out_ready). With PIPE_OUT=0, adv1 = v1 & out_ready.
- ROM address:
  - cry_addr = acc ? in_pix[15:8] : color1.
  - This keeps ROM data consistent with S1 while S1 is stalled: the ROM re-reads color1 every cycle.
  - rom_* sampled while v1 is high always corresponds to color1.
- Arithmetic, CRY pixel:
  - comp = (base*y1 + base) >> 8, with base = rom_*.
  - Uses a 16-bit product plus an 8-bit add, result truncated to 8 bits.
  - Y=0 gives 0; Y=0xFF gives exactly base. No overflow is possible (max 0xFF).
- Arithmetic, RGB16 pixel:
  - ROM data ignored.
  - R = {r5, r5[4:2]}, B = {b5, b5[4:2]}, G = {g6, g6[5:4]}.
- S2 loads when adv1; v2 clears when out_ready & ~adv1.
- out_valid = v2 (PIPE_OUT=1) or v1 (PIPE_OUT=0).
- Outputs are held stable while out_valid & ~out_ready.
- Latency: accept at cycle t gives out_valid at t+2 (PIPE_OUT=1) or t+1 (PIPE_OUT=0).
- Throughput: 1 pixel/clock when out_ready is held high.
- Simultaneous events:
  - Accept into an S1 that is advancing in the same cycle is allowed; no bubble.
  - out_ready low with both stages full: in_ready=0 and cry_addr=color1.
- Mode changes per pixel with no bubble.
- Reset (async assert, synchronous-style deassert handled upstream):
  - v1=v2=0, out_r/g/b=0, y1=color1=cry1=rgb1=0.
  - cry_addr=0 (in_valid ignored while resetl low), in_ready=0 while resetl low.
  - Reset mid-stream discards all in-flight pixels; no partial output.

Decomposition:
- Package cry_pkg holds:
  - CRY field widths/offsets (CRY_C_MSB=15, CRY_R_MSB=11, CRY_Y_MSB=7).
  - RGB16 field offsets.
  - A function expanding an n-bit field to 8 bits.
- One sub-module, cry_scale8: pure combinational (base, y) -> comp. Instantiated 3x.

Test Plan (bench uses behavioural registered-ROM models loaded with the team's CRY tables):
- CRY pix 0x00FF, out_ready=1 -> cry_addr=0x00; 2 cycles later B=0xFF (base 0xFF, Y=0xFF passes base through).
- CRY pix 0x1F80 -> B base 0xDD, result (221*128+221)>>8 = 0x6F; CRY pix 0x8F80 -> B=0x00.
- RGB16 pix 0xFFFF, in_cry=0 -> out 0xFF/0xFF/0xFF; pix 0x8420 (R=0x10, B=0x10, G=0x20) -> R=0x84, B=0x84, G=0x82.
- Backpressure: 4 back-to-back CRY pixels, out_ready low for 3 cycles after the first out_valid -> outputs held stable, in_ready=0 with S1 full, cry_addr=color1, then all 4 delivered in order with correct values.
- Y=0x00 with any colour -> 0/0/0; mixed CRY/RGB16 alternating every cycle at full rate -> no bubbles, correct per-pixel mode.
- Assert resetl low with both stages full -> out_valid=0 and outputs 0 immediately; after release, the first new pixel emerges at t+2 and no stale pixel appears.
